// File: rtl/i2c_txn_sequencer_pkg.sv
// Shared encodings for the I2C transaction sequencer: engine opcodes, response codes, FSM states.
package i2c_txn_sequencer_pkg;

   localparam logic [2:0] k_op_none    = 3'd0;
   localparam logic [2:0] k_op_start   = 3'd1;
   localparam logic [2:0] k_op_write   = 3'd2;
   localparam logic [2:0] k_op_read    = 3'd3;
   localparam logic [2:0] k_op_restart = 3'd4;
   localparam logic [2:0] k_op_stop    = 3'd5;

   localparam logic [1:0] k_err_ok      = 2'd0;
   localparam logic [1:0] k_err_addr    = 2'd1;
   localparam logic [1:0] k_err_data    = 2'd2;
   localparam logic [1:0] k_err_timeout = 2'd3;

   typedef enum logic [3:0] {
      k_seq_idle    = 4'd0,
      k_seq_start   = 4'd1,
      k_seq_dev_w   = 4'd2,
      k_seq_reg     = 4'd3,
      k_seq_wdata   = 4'd4,
      k_seq_restart = 4'd5,
      k_seq_dev_r   = 4'd6,
      k_seq_read    = 4'd7,
      k_seq_stop    = 4'd8,
      k_seq_resp    = 4'd9
   } seq_state_e;

   typedef enum logic {
      k_ph_issue = 1'b0,
      k_ph_wait  = 1'b1
   } seq_phase_e;

   function automatic logic [2:0] state_op(seq_state_e s);
      logic [2:0] op;
      op = k_op_none;
      case (s)
         k_seq_start:                          op = k_op_start;
         k_seq_dev_w, k_seq_reg, k_seq_wdata,
         k_seq_dev_r:                          op = k_op_write;
         k_seq_restart:                        op = k_op_restart;
         k_seq_read:                           op = k_op_read;
         k_seq_stop:                           op = k_op_stop;
         default:                              op = k_op_none;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/i2c_txn_sequencer_watchdog.sv
// Hang watchdog for the sequencer: counts cycles spent in one command phase, flags expiry at TIMEOUT.
module i2c_seq_watchdog #(
   parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   logic [15:0] r_count;

   // Holds at TIMEOUT rather than wrapping; the sequencer leaves the phase on expiry anyway.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          r_count <= '0;
      else if (clear)                        r_count <= '0;
      else if (run && (r_count != TIMEOUT))  r_count <= r_count + 16'd1;
   end

   assign expired = run && (r_count == TIMEOUT);

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Register-level I2C transaction sequencer driving the byte engine.
// Optional address-NACK retry is enabled with `define I2C_SEQ_RETRY_EN (adds parameter RETRIES).
module i2c_txn_sequencer
   import i2c_txn_sequencer_pkg::*;
#(
   parameter logic [15:0] TIMEOUT = 16'hFFFF
`ifdef I2C_SEQ_RETRY_EN
 , parameter int unsigned RETRIES = 3
`endif
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_dev_addr,
   input  logic [7:0] req_reg_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [1:0] rsp_err,
   output logic [7:0] rsp_rdata,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [2:0] cmd_op,
   output logic [7:0] cmd_wdata,
   output logic       cmd_nack,
   input  logic       done_valid,
   input  logic       done_ack,
   input  logic [7:0] done_rdata,
   output logic       eng_abort
);

   seq_state_e r_state, w_next_state;
   seq_phase_e r_phase, w_next_phase;
   logic       r_rw;
   logic [6:0] r_dev_addr;
   logic [7:0] r_reg_addr, r_wdata, r_rdata, w_next_rdata;
   logic [1:0] r_err, w_next_err;
   logic       w_active, w_progress, w_expired, w_clear;
`ifdef I2C_SEQ_RETRY_EN
   logic [7:0] r_retry_ctr;
   logic       w_retry_inc;
`endif

   assign w_active   = (r_state != k_seq_idle) && (r_state != k_seq_resp);
   assign w_progress = (r_phase == k_ph_issue) ? cmd_ready : done_valid;
   assign w_clear    = (w_next_state != r_state) || (w_next_phase != r_phase);

   i2c_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (w_clear),
      .run     (w_active),
      .expired (w_expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= k_seq_idle;
         r_phase    <= k_ph_issue;
         r_rw       <= 1'b0;
         r_dev_addr <= '0;
         r_reg_addr <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_err      <= k_err_ok;
      end else begin
         r_state <= w_next_state;
         r_phase <= w_next_phase;
         r_rdata <= w_next_rdata;
         r_err   <= w_next_err;
         if ((r_state == k_seq_idle) && req_valid) begin
            r_rw       <= req_rw;
            r_dev_addr <= req_dev_addr;
            r_reg_addr <= req_reg_addr;
            r_wdata    <= req_wdata;
         end
      end
   end

`ifdef I2C_SEQ_RETRY_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                 r_retry_ctr <= '0;
      else if ((r_state == k_seq_idle) && req_valid) r_retry_ctr <= '0;
      else if (w_retry_inc)                         r_retry_ctr <= r_retry_ctr + 8'd1;
   end
`endif

   // A completed handshake or done always beats a watchdog expiry in the same cycle.
   always_comb begin
      w_next_state = r_state;
      w_next_phase = r_phase;
      w_next_err   = r_err;
      w_next_rdata = r_rdata;
      eng_abort    = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
      w_retry_inc  = 1'b0;
`endif
      case (r_state)
         k_seq_idle: begin
            if (req_valid) begin
               w_next_state = k_seq_start;
               w_next_phase = k_ph_issue;
               w_next_err   = k_err_ok;
               w_next_rdata = '0;
            end
         end
         k_seq_resp: w_next_state = k_seq_idle;
         default: begin
            if (w_progress && (r_phase == k_ph_issue)) begin
               w_next_phase = k_ph_wait;
            end else if (w_progress) begin
               w_next_phase = k_ph_issue;
               case (r_state)
                  k_seq_start:   w_next_state = k_seq_dev_w;
                  k_seq_dev_w: begin
                     w_next_state = done_ack ? k_seq_reg : k_seq_stop;
                     if (!done_ack) w_next_err = k_err_addr;
                  end
                  k_seq_reg: begin
                     w_next_state = !done_ack ? k_seq_stop : (r_rw ? k_seq_restart : k_seq_wdata);
                     if (!done_ack) w_next_err = k_err_data;
                  end
                  k_seq_wdata: begin
                     w_next_state = k_seq_stop;
                     if (!done_ack) w_next_err = k_err_data;
                  end
                  k_seq_restart: w_next_state = k_seq_dev_r;
                  k_seq_dev_r: begin
                     w_next_state = done_ack ? k_seq_read : k_seq_stop;
                     if (!done_ack) w_next_err = k_err_addr;
                  end
                  k_seq_read: begin
                     w_next_state = k_seq_stop;
                     w_next_rdata = done_rdata;
                  end
                  k_seq_stop: begin
                     w_next_state = k_seq_resp;
`ifdef I2C_SEQ_RETRY_EN
                     if ((r_err == k_err_addr) && (32'(r_retry_ctr) < RETRIES)) begin
                        w_next_state = k_seq_start;
                        w_next_err   = k_err_ok;
                        w_retry_inc  = 1'b1;
                     end
`endif
                  end
                  default:       w_next_state = k_seq_idle;
               endcase
            end else if (w_expired) begin
               eng_abort    = 1'b1;
               w_next_err   = k_err_timeout;
               w_next_state = k_seq_resp;
               w_next_phase = k_ph_issue;
            end
         end
      endcase
   end

   always_comb begin
      req_ready = (r_state == k_seq_idle);
      rsp_valid = (r_state == k_seq_resp);
      rsp_err   = rsp_valid ? r_err : k_err_ok;
      rsp_rdata = (rsp_valid && (r_err == k_err_ok)) ? r_rdata : 8'h00;
      cmd_valid = w_active && (r_phase == k_ph_issue);
      cmd_op    = w_active ? state_op(r_state) : k_op_none;
      cmd_nack  = (r_state == k_seq_read);
      case (r_state)
         k_seq_dev_w: cmd_wdata = {r_dev_addr, 1'b0};
         k_seq_reg:   cmd_wdata = r_reg_addr;
         k_seq_wdata: cmd_wdata = r_wdata;
         k_seq_dev_r: cmd_wdata = {r_dev_addr, 1'b1};
         default:     cmd_wdata = 8'h00;
      endcase
   end

endmodule
